// File: rtl/gray_monitor.sv
// Gray-code counter checker: converts, validates and counts Gray steps/wraps.
// Optional capture of the offending code pair: define GRAY_MON_CAPTURE_EN.
module gray_monitor #(
    parameter int WIDTH  = 3,
    parameter int STEP_W = 8,
    parameter int WRAP_W = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [WIDTH-1:0]  Gray,
    input  logic              Ovf,
    output logic [WIDTH-1:0]  Bin,
    output logic [STEP_W-1:0] Steps,
    output logic [WRAP_W-1:0] Wraps,
    output logic              Err,
    output logic [1:0]        ErrCode
`ifdef GRAY_MON_CAPTURE_EN
    ,
    output logic [WIDTH-1:0]  CapPrev,
    output logic [WIDTH-1:0]  CapCur
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        TRACK,
        ERROR
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] prev_gray;
    logic             prev_ovf;
    logic [WIDTH-1:0] cur_bin;
    logic [WIDTH-1:0] prev_bin;
    logic             is_hold;
    logic             is_step;
    logic             is_wrap;
    logic             is_resync;
    logic [1:0]       code;
    logic             inc_step;
    logic             inc_wrap;
    logic             set_err;

    function automatic logic [WIDTH-1:0] to_bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Classify the current sample against the previous one.
    always_comb begin
        cur_bin   = to_bin(Gray);
        prev_bin  = to_bin(prev_gray);
        is_hold   = (Gray == prev_gray) && (Ovf == prev_ovf);
        is_step   = (prev_bin != '1) && (cur_bin == prev_bin + WIDTH'(1))
                    && (Ovf == prev_ovf);
        is_wrap   = (prev_bin == '1) && (Gray == '0) && Ovf;
        is_resync = (Gray == '0) && !Ovf;
        if (prev_ovf && !Ovf && (Gray != '0)) begin
            code = 2'd2;
        end else if (!prev_ovf && Ovf) begin
            code = 2'd3;
        end else begin
            code = 2'd1;
        end
    end

    // Next-state and count/error strobes.
    always_comb begin
        state_n  = state;
        inc_step = 1'b0;
        inc_wrap = 1'b0;
        set_err  = 1'b0;
        unique case (state)
            IDLE: state_n = TRACK;
            TRACK: begin
                if (is_hold || is_resync) begin
                    state_n = TRACK;
                end else if (is_step) begin
                    inc_step = 1'b1;
                end else if (is_wrap) begin
                    inc_step = 1'b1;
                    inc_wrap = 1'b1;
                end else begin
                    state_n = ERROR;
                    set_err = 1'b1;
                end
            end
            ERROR: state_n = ERROR;
            default: state_n = IDLE;
        endcase
    end

    // State, history, saturating counters and sticky error.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            prev_gray <= '0;
            prev_ovf  <= 1'b0;
            Bin       <= '0;
            Steps     <= '0;
            Wraps     <= '0;
            Err       <= 1'b0;
            ErrCode   <= 2'd0;
        end else begin
            state     <= state_n;
            prev_gray <= Gray;
            prev_ovf  <= Ovf;
            Bin       <= cur_bin;
            if (inc_step && (Steps != '1)) begin
                Steps <= Steps + STEP_W'(1);
            end
            if (inc_wrap && (Wraps != '1)) begin
                Wraps <= Wraps + WRAP_W'(1);
            end
            if (set_err) begin
                Err     <= 1'b1;
                ErrCode <= code;
            end
        end
    end

`ifdef GRAY_MON_CAPTURE_EN
    // Latch the offending code pair on entry to ERROR.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            CapPrev <= '0;
            CapCur  <= '0;
        end else if (set_err) begin
            CapPrev <= prev_gray;
            CapCur  <= Gray;
        end
    end
`endif

endmodule

// File: tb/tb_gray_monitor.sv
// Scoreboard bench for gray_monitor: stimulus pushes expectations,
// a monitor pops and compares one entry per clock.
module tb_gray_monitor;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic [2:0] Gray = '0;
    logic       Ovf = 1'b0;

    logic [2:0] Bin;
    logic [7:0] Steps;
    logic [3:0] Wraps;
    logic       Err;
    logic [1:0] ErrCode;
    logic [2:0] s_bin;
    logic [2:0] s_steps;
    logic [0:0] s_wraps;
    logic       s_err;
    logic [1:0] s_code;
`ifdef GRAY_MON_CAPTURE_EN
    logic [2:0] CapPrev;
    logic [2:0] CapCur;
    logic [2:0] s_cp;
    logic [2:0] s_cc;
`endif

    gray_monitor #(.WIDTH(3), .STEP_W(8), .WRAP_W(4)) dut (
        .Clk(Clk), .Reset(Reset), .Gray(Gray), .Ovf(Ovf),
        .Bin(Bin), .Steps(Steps), .Wraps(Wraps),
        .Err(Err), .ErrCode(ErrCode)
`ifdef GRAY_MON_CAPTURE_EN
        , .CapPrev(CapPrev), .CapCur(CapCur)
`endif
    );

    gray_monitor #(.WIDTH(3), .STEP_W(3), .WRAP_W(1)) sat (
        .Clk(Clk), .Reset(Reset), .Gray(Gray), .Ovf(Ovf),
        .Bin(s_bin), .Steps(s_steps), .Wraps(s_wraps),
        .Err(s_err), .ErrCode(s_code)
`ifdef GRAY_MON_CAPTURE_EN
        , .CapPrev(s_cp), .CapCur(s_cc)
`endif
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic       chk;
        logic [2:0] bin;
        logic [7:0] steps;
        logic [3:0] wraps;
        logic       err;
        logic [1:0] code;
        logic       chk_cap;
        logic [2:0] cp;
        logic [2:0] cc;
        logic       chk_sat;
        logic [2:0] ss;
        logic       sw;
    } exp_t;

    exp_t q[$];
    exp_t nx = '0;
    int   n_chk = 0;
    int   n_fail = 0;
    logic [2:0] seq [7] = '{3'b001, 3'b011, 3'b010, 3'b110,
                            3'b111, 3'b101, 3'b100};

    task automatic cmp(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic ex(input logic [2:0] b, input logic [7:0] s,
                      input logic [3:0] w, input logic e,
                      input logic [1:0] c);
        nx.chk = 1'b1; nx.bin = b; nx.steps = s;
        nx.wraps = w; nx.err = e; nx.code = c;
    endtask

    task automatic ex_cap(input logic [2:0] p, input logic [2:0] c);
        nx.chk_cap = 1'b1; nx.cp = p; nx.cc = c;
    endtask

    task automatic ex_sat(input logic [2:0] s, input logic w);
        nx.chk_sat = 1'b1; nx.ss = s; nx.sw = w;
    endtask

    task automatic cyc(input logic r, input logic [2:0] g, input logic o);
        @(negedge Clk);
        Reset = r; Gray = g; Ovf = o;
        q.push_back(nx);
        nx = '0;
    endtask

    // Monitor: one expectation per clock, outputs sampled after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge Clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                if (e.chk) begin
                    cmp("bin", 32'(Bin), 32'(e.bin));
                    cmp("steps", 32'(Steps), 32'(e.steps));
                    cmp("wraps", 32'(Wraps), 32'(e.wraps));
                    cmp("err", 32'(Err), 32'(e.err));
                    cmp("errcode", 32'(ErrCode), 32'(e.code));
                end
`ifdef GRAY_MON_CAPTURE_EN
                if (e.chk_cap) begin
                    cmp("cap_prev", 32'(CapPrev), 32'(e.cp));
                    cmp("cap_cur", 32'(CapCur), 32'(e.cc));
                end
`endif
                if (e.chk_sat) begin
                    cmp("sat_steps", 32'(s_steps), 32'(e.ss));
                    cmp("sat_wraps", 32'(s_wraps), 32'(e.sw));
                end
            end
        end
    end

    initial begin
        // reset state
        ex(3'd0, 8'd0, 4'd0, 1'b0, 2'd0); ex_sat(3'd0, 1'b0);
        cyc(1, 3'b000, 0);
        cyc(1, 3'b000, 0);
        // full Gray pass
        ex(3'd0, 8'd0, 4'd0, 1'b0, 2'd0);
        cyc(0, 3'b000, 0);
        for (int i = 0; i < 6; i++) cyc(0, seq[i], 0);
        ex(3'd7, 8'd7, 4'd0, 1'b0, 2'd0); ex_sat(3'd7, 1'b0);
        cyc(0, 3'b100, 0);
        // wrap then step
        ex(3'd0, 8'd8, 4'd1, 1'b0, 2'd0);
        cyc(0, 3'b000, 1);
        ex(3'd1, 8'd9, 4'd1, 1'b0, 2'd0); ex_sat(3'd7, 1'b1);
        cyc(0, 3'b001, 1);
        // hold at 011
        ex(3'd2, 8'd10, 4'd1, 1'b0, 2'd0);
        cyc(0, 3'b011, 1);
        for (int i = 0; i < 3; i++) cyc(0, 3'b011, 1);
        ex(3'd2, 8'd10, 4'd1, 1'b0, 2'd0); ex_sat(3'd7, 1'b1);
        cyc(0, 3'b011, 1);
        // illegal jump 001 -> 010
        cyc(1, 3'b000, 0);
        cyc(0, 3'b001, 0);
        ex(3'd3, 8'd0, 4'd0, 1'b1, 2'd1); ex_cap(3'b001, 3'b010);
        cyc(0, 3'b010, 0);
        ex(3'd2, 8'd0, 4'd0, 1'b1, 2'd1); ex_cap(3'b001, 3'b010);
        cyc(0, 3'b011, 0);
        // Ovf rose without wrap
        cyc(1, 3'b000, 0);
        cyc(0, 3'b001, 0);
        ex(3'd2, 8'd0, 4'd0, 1'b1, 2'd3); ex_cap(3'b001, 3'b011);
        cyc(0, 3'b011, 1);
        // Ovf dropped
        cyc(1, 3'b000, 0);
        cyc(0, 3'b011, 1);
        ex(3'd2, 8'd0, 4'd0, 1'b1, 2'd2); ex_cap(3'b011, 3'b011);
        cyc(0, 3'b011, 0);
        // resync 110 -> 000
        cyc(1, 3'b000, 0);
        ex(3'd4, 8'd0, 4'd0, 1'b0, 2'd0);
        cyc(0, 3'b110, 0);
        ex(3'd0, 8'd0, 4'd0, 1'b0, 2'd0); ex_cap(3'b000, 3'b000);
        cyc(0, 3'b000, 0);
        ex(3'd1, 8'd1, 4'd0, 1'b0, 2'd0);
        cyc(0, 3'b001, 0);
        // two full laps: saturation on narrow instance
        cyc(1, 3'b000, 0);
        cyc(0, 3'b000, 0);
        for (int i = 0; i < 7; i++) cyc(0, seq[i], 0);
        cyc(0, 3'b000, 1);
        for (int i = 0; i < 7; i++) cyc(0, seq[i], 1);
        ex(3'd0, 8'd16, 4'd2, 1'b0, 2'd0); ex_sat(3'd7, 1'b1);
        cyc(0, 3'b000, 1);
        ex(3'd1, 8'd17, 4'd2, 1'b0, 2'd0);
        cyc(0, 3'b001, 1);
        // mid-stream reset, first sample after it never flagged
        ex(3'd0, 8'd0, 4'd0, 1'b0, 2'd0); ex_sat(3'd0, 1'b0);
        cyc(1, 3'b011, 1);
        ex(3'd2, 8'd0, 4'd0, 1'b0, 2'd0);
        cyc(0, 3'b011, 1);
        ex(3'd5, 8'd0, 4'd0, 1'b1, 2'd1); ex_cap(3'b011, 3'b111);
        cyc(0, 3'b111, 1);
        // drain
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge Clk);
        repeat (2) @(posedge Clk);
        if (q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
